clk_ratio_meter: RTL and testbench



---
 rtl/clk_ratio_meter.sv | 170 +++++++++++++++++
 tb/tb_clk_ratio_meter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_ratio_meter.sv
// clk_ratio_meter: measures the period of an asynchronous divided clock
// (div_in) in clk cycles, decodes it back to the divide select k
// (period ~ BASE_PERIOD << k, k = 0..3) and flags a stalled feedback path.
// Optional build macro CLK_RATIO_AVG_EN: report the average of four
// consecutive periods instead of every single period.
module clk_ratio_meter #(
    parameter int CNT_W       = 16,
    parameter int BASE_PERIOD = 8,
    parameter int TOL         = 1,
    parameter int TIMEOUT     = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [1:0]       sel_est,
    output logic             ratio_ok,
    output logic             meas_valid,
    output logic             stall
);

    // Decode arithmetic is done two bits wider than the counter so that
    // BASE_PERIOD << 3 and the averaging sum never wrap.
    localparam int EXT_W = CNT_W + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;
    logic [EXT_W-1:0] meas_val;
    logic             meas_done;
    logic [2:0]       dec;

`ifdef CLK_RATIO_AVG_EN
    logic [EXT_W-1:0] acc;
    logic [1:0]       acc_n;
    logic [EXT_W-1:0] acc_sum;
`endif

    // Returns {hit, k}; the lowest k whose nominal period lies within TOL wins.
    function automatic logic [2:0] decode_sel(input logic [EXT_W-1:0] val);
        logic [2:0]       res;
        logic [EXT_W-1:0] tgt;
        logic [EXT_W-1:0] diff;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            tgt  = EXT_W'(BASE_PERIOD) << k;
            diff = (val >= tgt) ? (val - tgt) : (tgt - val);
            if (diff <= EXT_W'(TOL)) begin
                res = {1'b1, 2'(k)};
            end
        end
        return res;
    endfunction

    assign rise        = s2 & ~s3;
    assign cnt_inc     = (&cnt) ? cnt : cnt + CNT_W'(1);
    assign timeout_hit = (cnt >= CNT_W'(TIMEOUT));

    // Select the value to publish on a rise and whether this rise publishes.
    always_comb begin
        meas_val  = EXT_W'(cnt);
        meas_done = 1'b1;
`ifdef CLK_RATIO_AVG_EN
        acc_sum   = acc + EXT_W'(cnt);
        meas_val  = acc_sum >> 2;
        meas_done = (acc_n == 2'd3);
`endif
        dec = decode_sel(meas_val);
    end

    // Synchroniser, measurement FSM, period counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            period     <= '0;
            sel_est    <= 2'd0;
            ratio_ok   <= 1'b0;
            meas_valid <= 1'b0;
            stall      <= 1'b0;
`ifdef CLK_RATIO_AVG_EN
            acc        <= '0;
            acc_n      <= 2'd0;
`endif
        end else begin
            s1         <= div_in;
            s2         <= s1;
            s3         <= s2;
            meas_valid <= 1'b0;
            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
                stall <= 1'b0;
`ifdef CLK_RATIO_AVG_EN
                acc   <= '0;
                acc_n <= 2'd0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARM;
                        cnt   <= '0;
                    end
                    ARM: begin
                        if (rise) begin
                            cnt   <= CNT_W'(1);
                            state <= MEAS;
                        end else if (timeout_hit) begin
                            stall <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    MEAS: begin
                        if (rise) begin
                            cnt <= CNT_W'(1);
                            if (meas_done) begin
                                period     <= meas_val[CNT_W-1:0];
                                ratio_ok   <= dec[2];
                                meas_valid <= 1'b1;
                                stall      <= 1'b0;
                                if (dec[2]) begin
                                    sel_est <= dec[1:0];
                                end
                            end
`ifdef CLK_RATIO_AVG_EN
                            if (meas_done) begin
                                acc   <= '0;
                                acc_n <= 2'd0;
                            end else begin
                                acc   <= acc_sum;
                                acc_n <= acc_n + 2'd1;
                            end
`endif
                        end else if (timeout_hit) begin
                            stall <= 1'b1;
                            cnt   <= '0;
                            state <= ARM;
`ifdef CLK_RATIO_AVG_EN
                            acc   <= '0;
                            acc_n <= 2'd0;
`endif
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed testbench for clk_ratio_meter (default build and CLK_RATIO_AVG_EN).
module tb_clk_ratio_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        div_in;
    logic [15:0] period;
    logic [1:0]  sel_est;
    logic        ratio_ok;
    logic        meas_valid;
    logic        stall;

    clk_ratio_meter #(
        .CNT_W(16), .BASE_PERIOD(8), .TOL(1), .TIMEOUT(1024)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .div_in(div_in),
        .period(period), .sel_est(sel_est), .ratio_ok(ratio_ok),
        .meas_valid(meas_valid), .stall(stall)
    );

    always #5 clk = ~clk;

`ifdef CLK_RATIO_AVG_EN
    localparam int RISES_TO_FIRST = 5;
`else
    localparam int RISES_TO_FIRST = 2;
`endif

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // div_in generator: high/low phase lengths in clk cycles, latched at each rise
    bit run = 1'b0;
    int hi_len = 4, lo_len = 4;
    int cur_hi = 4, cur_lo = 4;
    int ph = 0;
    int q_hi[$];
    int q_lo[$];

    initial begin
        div_in = 1'b0;
        forever begin
            @(negedge clk);
            if (!run) begin
                div_in = 1'b0;
                ph     = 0;
                cur_hi = hi_len;
                cur_lo = lo_len;
            end else begin
                ph++;
                if (div_in && ph >= cur_hi) begin
                    div_in = 1'b0;
                    ph     = 0;
                end else if (!div_in && ph >= cur_lo) begin
                    div_in = 1'b1;
                    ph     = 0;
                    if (q_hi.size() > 0) begin
                        cur_hi = q_hi.pop_front();
                        cur_lo = q_lo.pop_front();
                    end else begin
                        cur_hi = hi_len;
                        cur_lo = lo_len;
                    end
                end
            end
        end
    end

    // Observed meas_valid pulses and div_in rises
    int mv_count = 0;
    int rises    = 0;
    always @(negedge clk) if (meas_valid === 1'b1) mv_count++;
    always @(posedge div_in) rises++;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_mv(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (meas_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    bit seen;
    bit prev_stall;
    int base;
    int r0;
    int n_mv;

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        cycles(3);
        check("rst_period", 32'(period), 0);
        check("rst_sel", 32'(sel_est), 0);
        check("rst_ratio_ok", 32'(ratio_ok), 0);
        check("rst_meas_valid", 32'(meas_valid), 0);
        check("rst_stall", 32'(stall), 0);
        rst = 1'b0;
        cycles(2);

        // period 8
        en = 1'b1; run = 1'b1;
        cycles(200);
        base = mv_count;
        cycles(80);
        n_mv = mv_count - base;
`ifdef CLK_RATIO_AVG_EN
        check("mv_rate_p8", 32'(n_mv >= 2 && n_mv <= 3), 1);
`else
        check("mv_rate_p8", 32'(n_mv), 10);
`endif
        check("p8_period", 32'(period), 8);
        check("p8_sel", 32'(sel_est), 0);
        check("p8_ok", 32'(ratio_ok), 1);
        check("p8_stall", 32'(stall), 0);

        // period 32, then 64
        hi_len = 16; lo_len = 16;
        cycles(500);
        check("p32_period", 32'(period), 32);
        check("p32_sel", 32'(sel_est), 2);
        check("p32_ok", 32'(ratio_ok), 1);
        hi_len = 32; lo_len = 32;
        cycles(900);
        check("p64_period", 32'(period), 64);
        check("p64_sel", 32'(sel_est), 3);
        check("p64_ok", 32'(ratio_ok), 1);

        // period 20 (no match), then 15 (16-1 within TOL)
        hi_len = 10; lo_len = 10;
        cycles(400);
        check("p20_period", 32'(period), 20);
        check("p20_ok", 32'(ratio_ok), 0);
`ifndef CLK_RATIO_AVG_EN
        check("p20_sel_hold", 32'(sel_est), 3);
`endif
        hi_len = 7; lo_len = 8;
        cycles(300);
        check("p15_period", 32'(period), 15);
        check("p15_ok", 32'(ratio_ok), 1);
        check("p15_sel", 32'(sel_est), 1);

        // stall: stop toggling right after a measurement
        hi_len = 4; lo_len = 4;
        cycles(200);
        wait_mv(200, seen);
        check("mv_before_stop", 32'(seen), 1);
        run = 1'b0;
        cycles(1);
        base = mv_count;
        cycles(1022);
        check("stall_before_timeout", 32'(stall), 0);
        cycles(1);
        check("stall_at_timeout", 32'(stall), 1);
        check("no_mv_in_stall", 32'(mv_count - base), 0);
        run = 1'b1;
        seen = 1'b0;
        prev_stall = stall;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (meas_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            prev_stall = stall;
        end
        check("mv_after_restart", 32'(seen), 1);
        check("stall_held_until_mv", 32'(prev_stall), 1);
        check("stall_clear_with_mv", 32'(stall), 0);
        check("restart_period", 32'(period), 8);

        // reset mid-measurement
        hi_len = 16; lo_len = 16;
        cycles(500);
        check("pre_rst_sel", 32'(sel_est), 2);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("midrst_period", 32'(period), 0);
        check("midrst_sel", 32'(sel_est), 0);
        check("midrst_ok", 32'(ratio_ok), 0);
        check("midrst_mv", 32'(meas_valid), 0);
        check("midrst_stall", 32'(stall), 0);
        cycles(500);
        check("post_rst_period", 32'(period), 32);
        check("post_rst_sel", 32'(sel_est), 2);

        // en=0 during MEAS: outputs hold, no pulses
        en = 1'b0;
        cycles(1);
        base = mv_count;
        cycles(200);
        check("en0_no_mv", 32'(mv_count - base), 0);
        check("en0_period_hold", 32'(period), 32);
        check("en0_sel_hold", 32'(sel_est), 2);
        check("en0_ok_hold", 32'(ratio_ok), 1);
        check("en0_stall", 32'(stall), 0);

        // re-enable during a low phase; count rises to the first pulse
        for (int i = 0; i < 100 && div_in !== 1'b1; i++) @(negedge clk);
        for (int i = 0; i < 100 && div_in !== 1'b0; i++) @(negedge clk);
        en = 1'b1;
        r0 = rises;
        wait_mv(500, seen);
        check("reen_mv_seen", 32'(seen), 1);
        check("reen_rises_to_first_mv", 32'(rises - r0), 32'(RISES_TO_FIRST));
        check("reen_period", 32'(period), 32);

`ifdef CLK_RATIO_AVG_EN
        // averaging window of periods 7, 9, 8, 8
        en = 1'b0; run = 1'b0;
        cycles(5);
        hi_len = 50; lo_len = 50;
        q_hi.push_back(3); q_lo.push_back(4);
        q_hi.push_back(4); q_lo.push_back(5);
        q_hi.push_back(4); q_lo.push_back(4);
        q_hi.push_back(4); q_lo.push_back(4);
        base = mv_count;
        en = 1'b1; run = 1'b1;
        wait_mv(300, seen);
        check("avg_mv_seen", 32'(seen), 1);
        check("avg_period", 32'(period), 8);
        check("avg_sel", 32'(sel_est), 0);
        check("avg_ok", 32'(ratio_ok), 1);
        cycles(60);
        check("avg_single_mv", 32'(mv_count - base), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
